cluster_tx_scheduler: RTL

Sequences the eight per-bunch-crossing clusters from the cluster packer onto a single one-cluster-per-cycle stream toward the trigger link serializer. Lives in the `clock4x` domain directly downstream of the packer. Captures each cluster set, discards invalid slots, and buffers valid clusters in a 2-write/1-read FIFO. Drains them under a valid/ready handshake and accounts for every cluster dropped on overflow.

---
 rtl/cluster_pkg.sv | 26 ++
 rtl/cluster_sched_fifo.sv | 49 ++++
 rtl/cluster_tx_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cluster_pkg.sv
// Shared cluster types and constants for the trigger-link cluster path.
package cluster_pkg;

    localparam int unsigned CLUSTER_W    = 14;
    localparam int unsigned ADR_W        = 11;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned NUM_CLUSTERS = 8;
    localparam int unsigned MAX_ADR      = 1536;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [ADR_W-1:0] adr;
    } cluster_t;

    typedef enum logic [0:0] {StIdle, StDrain} sched_state_e;

    function automatic logic [3:0] popcount8(input logic [NUM_CLUSTERS-1:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            n = n + 4'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cluster_sched_fifo.sv
// Circular buffer of {first, cluster} words: two ordered write ports, one FWFT read port.
module cluster_sched_fifo
    import cluster_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en0,
    input  logic [CLUSTER_W:0]     wr_data0,
    input  logic                   wr_en1,
    input  logic [CLUSTER_W:0]     wr_data1,
    input  logic                   rd_en,
    output logic [CLUSTER_W:0]     rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CLUSTER_W:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               pop;

    assign pop = rd_en && (count_q != '0);

    // Port 1 is only ever used together with port 0, so it lands in the following slot.
    always_ff @(posedge clk) begin
        if (wr_en0) mem[wr_ptr_q] <= wr_data0;
        if (wr_en1) mem[wr_ptr_q + AW'(1)] <= wr_data1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(wr_en0) + AW'(wr_en1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(wr_en0) + (AW+1)'(wr_en1) - (AW+1)'(pop);
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/cluster_tx_scheduler.sv
// Serialises eight-cluster sets into a one-cluster-per-cycle valid/ready stream.
// Optional statistics (drop count, high water) enabled by CLUSTER_SCHED_STATS_EN.
module cluster_tx_scheduler
    import cluster_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DROP_W = 16
) (
    input  logic                              clock4x,
    input  logic                              global_reset,
    input  logic [NUM_CLUSTERS*CLUSTER_W-1:0] clusters_i,
    input  logic                              clusters_valid_i,
    output logic [CLUSTER_W-1:0]              cluster_o,
    output logic                              cluster_first_o,
    output logic                              cluster_valid_o,
    input  logic                              cluster_ready_i,
    output logic                              busy_o,
    output logic [$clog2(DEPTH):0]            fifo_count_o,
    output logic [DROP_W-1:0]                 drop_count_o,
    output logic [$clog2(DEPTH):0]            high_water_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sched_state_e                      state_q;
    logic [NUM_CLUSTERS*CLUSTER_W-1:0] stage_q;
    logic [NUM_CLUSTERS-1:0]           mask_q;
    logic [NUM_CLUSTERS-1:0]           new_mask;
    logic [NUM_CLUSTERS-1:0]           rem_mask;
    logic                              first_pend_q;
    logic [2:0]                        sel0;
    logic [2:0]                        sel1;
    logic                              sel0_v;
    logic                              sel1_v;
    logic                              acc0;
    logic                              acc1;
    logic [CW-1:0]                     count;
    logic [CLUSTER_W:0]                rd_data;

    always_comb begin
        new_mask = '0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            new_mask[k] = clusters_i[k*CLUSTER_W +: ADR_W] < ADR_W'(MAX_ADR);
        end
    end

    // Scan downward so sel0 ends on the lowest pending slot and sel1 on the next one.
    always_comb begin
        sel0   = '0;
        sel1   = '0;
        sel0_v = 1'b0;
        sel1_v = 1'b0;
        for (int k = NUM_CLUSTERS - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                sel1   = sel0;
                sel1_v = sel0_v;
                sel0   = 3'(k);
                sel0_v = 1'b1;
            end
        end
        rem_mask = mask_q;
        if (sel0_v) rem_mask[sel0] = 1'b0;
        if (sel1_v) rem_mask[sel1] = 1'b0;
    end

    // Free space is judged on the start-of-cycle count; a concurrent pop gives no credit.
    assign acc0 = sel0_v && (count < CW'(DEPTH));
    assign acc1 = sel1_v && (count < CW'(DEPTH - 1));

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_q      <= StIdle;
            stage_q      <= '0;
            mask_q       <= '0;
            first_pend_q <= 1'b0;
        end else if (clusters_valid_i) begin
            stage_q      <= clusters_i;
            mask_q       <= new_mask;
            first_pend_q <= 1'b1;
            state_q      <= (|new_mask) ? StDrain : StIdle;
        end else begin
            mask_q       <= rem_mask;
            first_pend_q <= first_pend_q && !acc0;
            state_q      <= (|rem_mask) ? StDrain : StIdle;
        end
    end

    assign busy_o = (state_q == StDrain);

    cluster_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clock4x),
        .rst      (global_reset),
        .wr_en0   (acc0),
        .wr_data0 ({first_pend_q, stage_q[sel0*CLUSTER_W +: CLUSTER_W]}),
        .wr_en1   (acc1),
        .wr_data1 ({1'b0, stage_q[sel1*CLUSTER_W +: CLUSTER_W]}),
        .rd_en    (cluster_valid_o && cluster_ready_i),
        .rd_data  (rd_data),
        .count    (count)
    );

    assign cluster_valid_o = (count != '0);
    assign cluster_o       = cluster_valid_o ? rd_data[CLUSTER_W-1:0] : '0;
    assign cluster_first_o = cluster_valid_o && rd_data[CLUSTER_W];
    assign fifo_count_o    = count;

`ifdef CLUSTER_SCHED_STATS_EN
    logic [3:0]        drop_inc;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_q;
    logic [CW-1:0]     high_q;

    // A restart abandons whatever the current cycle's pushes leave behind.
    always_comb begin
        drop_inc = 4'(sel0_v && !acc0) + 4'(sel1_v && !acc1);
        if (clusters_valid_i) drop_inc = drop_inc + popcount8(rem_mask);
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            drop_q <= '0;
            high_q <= '0;
        end else begin
            drop_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            if (count > high_q) high_q <= count;
        end
    end

    assign drop_count_o = drop_q;
    assign high_water_o = high_q;
`else
    assign drop_count_o = '0;
    assign high_water_o = '0;
`endif

endmodule
